// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bundle: select/offset/target in, PC, link and stack status out.
// Latency: none; the bundle only carries wires.
// Backpressure: stall travels with the select and freezes the sequencer at the edge.
interface pc_sequencer_if #(
    parameter int WIDTH        = 64,
    parameter int OFFSET_WIDTH = 26,
    parameter int STACK_DEPTH  = 4
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic                    stall;
    logic [2:0]              ps;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [WIDTH-1:0]        target;
    logic [WIDTH-1:0]        pc;
    logic [WIDTH-1:0]        pc4;
    logic [CW-1:0]           stack_count;
    logic                    stack_full;
    logic                    stack_empty;
    logic                    ovf;
    logic                    unf;
    logic                    bad_ps;

    // The fetch control logic drives the select side.
    modport master (
        output stall, ps, offset, target,
        input  pc, pc4, stack_count, stack_full, stack_empty, ovf, unf, bad_ps
    );

    // The sequencer consumes the select side and presents PC state.
    modport slave (
        input  stall, ps, offset, target,
        output pc, pc4, stack_count, stack_full, stack_empty, ovf, unf, bad_ps
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with hold/inc/abs/rel/indirect/call/return and a return-address stack.
// Latency: one edge from select to new pc; pc4 and stack status are combinational from state.
// Backpressure: stall=1 freezes pc, stack, count and sticky flags at the edge.
module pc_sequencer #(
    parameter int               WIDTH        = 64,
    parameter int               OFFSET_WIDTH = 26,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 4
) (
    input  logic          clock,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int             PW         = $clog2(STACK_DEPTH);
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        PS_HOLD = 3'b000,
        PS_INC  = 3'b001,
        PS_ABS  = 3'b010,
        PS_REL  = 3'b011,
        PS_IND  = 3'b100,
        PS_CALL = 3'b101,
        PS_RET  = 3'b110,
        PS_RSVD = 3'b111
    } ps_e;

    ps_e              sel;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             set_bad;
    logic             ovf_q;
    logic             unf_q;
    logic             bad_q;

    assign sel     = ps_e'(bus.ps);
    assign ext     = {{(WIDTH-OFFSET_WIDTH){bus.offset[OFFSET_WIDTH-1]}}, bus.offset};
    assign sh      = {ext[WIDTH-3:0], 2'b00};
    assign pc4     = pc_q + WIDTH'(4);
    // wr_ptr names the next free slot, so the newest entry sits just below it;
    // when full, wr_ptr also names the oldest entry, which a push overwrites.
    assign top_ptr = wr_ptr - 1'b1;
    assign top     = stack_mem[top_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

    // Next-PC selection and stack operation decode.
    always_comb begin
        pc_next = pc_q;
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_bad = 1'b0;
        case (sel)
            PS_HOLD: pc_next = pc_q;
            PS_INC:  pc_next = pc4;
            PS_ABS:  pc_next = sh;
            PS_REL:  pc_next = pc4 + sh;
            PS_IND:  pc_next = {bus.target[WIDTH-1:2], 2'b00};
            PS_CALL: begin
                pc_next = pc4 + sh;
                do_push = 1'b1;
            end
            PS_RET: begin
                // An empty stack falls through to the next sequential instruction.
                pc_next = empty ? pc4 : top;
                do_pop  = 1'b1;
            end
            PS_RSVD: set_bad = 1'b1;
            default: pc_next = pc_q;
        endcase
    end

    // Architectural state: pc, stack pointer/count and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q   <= RESET_VECTOR;
            wr_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else if (!bus.stall) begin
            pc_q <= pc_next;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (full) begin
                    ovf_q <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (do_pop) begin
                if (empty) begin
                    unf_q <= 1'b1;
                end else begin
                    wr_ptr <= top_ptr;
                    count  <= count - 1'b1;
                end
            end
            if (set_bad) begin
                bad_q <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clock) begin
        if (!bus.stall && do_push) begin
            stack_mem[wr_ptr] <= pc4;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.stack_count = count;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.ovf         = ovf_q;
    assign bus.unf         = unf_q;
    assign bus.bad_ps      = bad_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed checks of pc_sequencer against a queue-based reference model.
// Latency: expectations are pushed at the driving negedge and checked 1 time unit after the next posedge.
// Backpressure: stall is exercised directly and by random injection.
module tb_pc_sequencer;
    localparam int          WIDTH = 64;
    localparam int          OW    = 26;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RV    = 64'h1000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pc_sequencer_if #(.WIDTH(WIDTH), .OFFSET_WIDTH(OW), .STACK_DEPTH(DEPTH)) bus ();

    pc_sequencer #(
        .WIDTH(WIDTH), .OFFSET_WIDTH(OW), .RESET_VECTOR(RV), .STACK_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] pc;
        int          count;
        bit          ovf;
        bit          unf;
        bit          bad;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_stack[$];
    bit          m_ovf, m_unf, m_bad;
    int          checks   = 0;
    int          failures = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_state(input exp_t e);
        cmp({e.tag, ".pc"},    bus.pc, e.pc);
        cmp({e.tag, ".pc4"},   bus.pc4, e.pc + 64'd4);
        cmp({e.tag, ".count"}, 64'(bus.stack_count), 64'(e.count));
        cmp({e.tag, ".full"},  64'(bus.stack_full), 64'(e.count == DEPTH));
        cmp({e.tag, ".empty"}, 64'(bus.stack_empty), 64'(e.count == 0));
        cmp({e.tag, ".ovf"},   64'(bus.ovf), 64'(e.ovf));
        cmp({e.tag, ".unf"},   64'(bus.unf), 64'(e.unf));
        cmp({e.tag, ".bad"},   64'(bus.bad_ps), 64'(e.bad));
    endtask

    function automatic exp_t snap(input string tag);
        exp_t e;
        e.pc    = m_pc;
        e.count = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.bad   = m_bad;
        e.tag   = tag;
        return e;
    endfunction

    task automatic model_reset();
        m_pc = RV;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
        m_bad = 0;
    endtask

    // Reference behaviour: stack is a bounded list of addresses, newest at the back.
    task automatic model_update(input logic st, input logic [2:0] p,
                                input logic [OW-1:0] off, input logic [63:0] tgt);
        logic signed [OW-1:0] soff;
        logic [63:0]          disp;
        logic [63:0]          nxt;
        soff = off;
        disp = 64'(soff) * 64'd4;
        nxt  = m_pc + 64'd4;
        if (st) return;
        case (p)
            3'd0: ;
            3'd1: m_pc = nxt;
            3'd2: m_pc = disp;
            3'd3: m_pc = nxt + disp;
            3'd4: m_pc = tgt & ~64'd3;
            3'd5: begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_ovf = 1;
                end
                m_stack.push_back(nxt);
                m_pc = nxt + disp;
            end
            3'd6: begin
                if (m_stack.size() == 0) begin
                    m_unf = 1;
                    m_pc  = nxt;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
            default: m_bad = 1;
        endcase
    endtask

    task automatic step(input logic st, input logic [2:0] p, input logic [OW-1:0] off,
                        input logic [63:0] tgt, input string tag);
        @(negedge clock);
        bus.stall  = st;
        bus.ps     = p;
        bus.offset = off;
        bus.target = tgt;
        model_update(st, p, off, tgt);
        sb_q.push_back(snap(tag));
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: every cycle presents a new state, compared against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_state(e);
            end
        end
    end

    initial begin : driver
        logic [OW-1:0] roff;
        bus.stall  = 1'b0;
        bus.ps     = 3'd0;
        bus.offset = '0;
        bus.target = '0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_state(snap("reset"));
        @(negedge clock);
        reset = 1'b0;

        step(0, 3'd1, '0, '0, "inc1");
        step(0, 3'd1, '0, '0, "inc2");
        step(0, 3'd1, '0, '0, "inc3");
        step(0, 3'd2, OW'(26'h800), '0, "abs2000");
        step(0, 3'd3, OW'(-2), '0, "rel_neg");
        step(0, 3'd2, OW'(26'h10), '0, "abs40");
        step(0, 3'd4, '0, 64'h3007, "ind");
        step(0, 3'd2, OW'(26'h40), '0, "abs100");
        for (int i = 0; i < 5; i++) step(0, 3'd5, '0, '0, $sformatf("call%0d", i));
        for (int i = 0; i < 4; i++) step(0, 3'd6, '0, '0, $sformatf("ret%0d", i));
        step(0, 3'd2, OW'(26'h140), '0, "abs500");
        step(0, 3'd6, '0, '0, "ret_empty");
        step(0, 3'd1, '0, '0, "unf_sticky");
        for (int i = 0; i < 3; i++) step(1, 3'd5, '0, '0, $sformatf("stall%0d", i));
        step(0, 3'd5, '0, '0, "unstall_call");
        step(0, 3'd6, '0, '0, "call_ret");
        step(0, 3'd7, '0, '0, "rsvd");
        step(0, 3'd2, OW'(-1), '0, "abs_top");
        step(0, 3'd1, '0, '0, "wrap");

        for (int i = 0; i < 300; i++) begin
            roff = OW'($urandom);
            if ($urandom_range(0, 1) == 0) roff = OW'($signed(8'($urandom)));
            step($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), roff,
                 {$urandom, $urandom}, $sformatf("rnd%0d", i));
        end
        drain();

        // Asynchronous reset between edges, then held across a call edge.
        @(posedge clock);
        #3;
        bus.stall = 1'b0;
        bus.ps    = 3'd5;
        reset     = 1'b1;
        #1;
        model_reset();
        check_state(snap("async_reset"));
        @(posedge clock);
        #1;
        check_state(snap("reset_call_edge"));
        @(negedge clock);
        reset   = 1'b0;
        bus.ps  = 3'd0;
        step(0, 3'd5, OW'(3), '0, "post_call");
        step(0, 3'd6, '0, '0, "post_ret");
        step(0, 3'd6, '0, '0, "post_ret_empty");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle/pipelined core fetch stage. Holds the fetch PC and computes the next PC from a 3-bit select: hold, increment, absolute, PC-relative, register-indirect, call and return. Adds stall, a hardware return-address stack, and sticky overflow/underflow flags. Feeds instruction ROM address (`pc`) and link value (`pc4`).

## Interface

Parameters:
- WIDTH, 64, PC/address width in bits (≥ 32).
- OFFSET_WIDTH, 26, width of the branch offset field (< WIDTH - 2).
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits, word aligned).
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥ 2).

Ports:
- clock  in  1  system clock, rising edge active.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  when 1, no architectural state changes at the edge.
- ps  in  3  next-PC select (encoding under Operation).
- offset  in  OFFSET_WIDTH  signed word offset / absolute word index.
- target  in  WIDTH  register-indirect target address.
- pc  out  WIDTH  current fetch PC (registered).
- pc4  out  WIDTH  pc + 4 (combinational).
- stack_count  out  log2(STACK_DEPTH)+1  valid return-stack entries.
- stack_full  out  1  stack_count == STACK_DEPTH.
- stack_empty  out  1  stack_count == 0.
- ovf  out  1  sticky: call issued while stack full.
- unf  out  1  sticky: return issued while stack empty.
- bad_ps  out  1  sticky: reserved select 111 seen.

## Operation

- ext = sign-extend(offset) to WIDTH; sh = ext << 2. All adds wrap modulo 2^WIDTH; no carry out.
- Next-PC select (ps):
  - 000 hold: pc unchanged.
  - 001 increment: pc ← pc4.
  - 010 absolute: pc ← sh.
  - 011 relative: pc ← pc4 + sh.
  - 100 indirect: pc ← {target[WIDTH-1:2], 2'b00} (low bits forced zero).
  - 101 call: pc ← pc4 + sh; push pc4.
  - 110 return: pc ← top of stack; pop.
  - 111 reserved: pc unchanged; bad_ps ← 1.
- Return stack: circular buffer, write pointer + count.
  - Push when not full: store at top, count+1.
  - Push when full: overwrite oldest entry (new becomes top), count stays STACK_DEPTH, ovf ← 1.
  - Pop when not empty: pc ← top, count-1.
  - Pop when empty: pc ← pc4 (fall through), count stays 0, unf ← 1.
- stall = 1: pc, stack contents, count and all sticky flags hold regardless of ps; pc4 still tracks pc.
- Sticky flags clear only on reset.

## Timing

- Reset (async, immediate on assertion): pc = RESET_VECTOR, pc4 = RESET_VECTOR + 4, stack_count = 0, stack_empty = 1, stack_full = 0, ovf = unf = bad_ps = 0. Stack entries need not be cleared.
- First update at first rising edge after reset deasserts, using ps/offset/target sampled at that edge.
- Next-PC is combinational from pc, ps, offset, target, top of stack; pc registers it at the rising edge: one-cycle latency from select to new pc.
- Call and return each complete in one edge. Return reads the top as it was before the edge. A call in cycle n followed by a return in cycle n+1 returns the address pushed at n.
- pc4, stack_full and stack_empty are combinational from registered state; no additional latency.
- Reset asserted mid-operation (e.g., during a call edge) wins: state goes straight to reset values, no push.

## Test plan

- Reset with RESET_VECTOR=0x1000; release; ps=001 for 3 edges -> pc 0x1004, 0x1008, 0x100C; pc4 = pc+4 each cycle.
- pc=0x2000, ps=011, offset=-2 -> pc=0x1FFC; ps=010, offset=0x10 -> pc=0x40; ps=100, target=0x3007 -> pc=0x3004.
- STACK_DEPTH=4: five calls (offset=0) from pc=0x100 -> stack_full=1, ovf=1, count=4; four returns yield 0x114, 0x110, 0x10C, 0x108; stack_empty=1.
- Return on empty stack at pc=0x500 -> pc=0x504, unf=1, count stays 0; further activity leaves unf set until reset.
- stall=1 with ps=101 for 3 edges -> pc, count, flags unchanged; stall low -> single push, count+1.
- ps=111 -> pc held, bad_ps=1; pc=0xFFFF_FFFF_FFFF_FFFC, ps=001 -> pc wraps to 0; async reset mid-cycle -> outputs to reset values without a clock edge.
